// File: rtl/i2c_controller_burst.sv
// Open-drain I2C burst master: multi-byte write/read, address/data NACK detection, valid/ready write side.
// Define CLOCK_STRETCH_EN to let a slave stretch SCL during the released half of each bit.
module i2c_controller_burst #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic             enable,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             ready,
    output logic             done,
    output logic             nack,
    inout  wire              i2c_sda,
    inout  wire              i2c_scl
);

    localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WAIT_WR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
    } state_t;

    state_t            state, state_nx;
    logic [QW-1:0]     qcnt;
    logic [1:0]        quarter;
    logic [2:0]        bitcnt;
    logic [7:0]        tx;
    logic [7:0]        rx;
    logic              rw_r;
    logic [LEN_W-1:0]  remaining;
    logic              samp;
    logic              scl_low, sda_low;
    logic              counting, stall, q_end, bit_end, sample_pt, shifting;

    assign counting  = (state != IDLE) && (state != WAIT_WR);
    assign q_end     = counting && !stall && (qcnt == Q_LAST);
    assign bit_end   = q_end && (quarter == 2'd3);
    assign sample_pt = q_end && (quarter == 2'd2);
    assign shifting  = (state == ADDR) || (state == WR_BYTE) || (state == RD_BYTE);

`ifdef CLOCK_STRETCH_EN
    // Freeze the quarter counter while a slave holds the released SCL low.
    assign stall = counting && quarter[1] && !scl_low && !i2c_scl;
`else
    logic unused_scl;
    assign unused_scl = i2c_scl;
    assign stall      = 1'b0;
`endif

    assign i2c_scl  = scl_low ? 1'b0 : 1'bz;
    assign i2c_sda  = sda_low ? 1'b0 : 1'bz;
    assign ready    = (state == IDLE);
    assign wr_ready = (state == WAIT_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        scl_low  = 1'b0;
        sda_low  = 1'b0;
        case (state)
            IDLE: if (enable) state_nx = START;
            START: begin
                sda_low = quarter[1];
                if (bit_end) state_nx = ADDR;
            end
            ADDR: begin
                scl_low = !quarter[1];
                sda_low = !tx[7];
                if (bit_end && bitcnt == 3'd7) state_nx = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_low = !quarter[1];
                if (bit_end) begin
                    if (samp || remaining == '0) state_nx = STOP;
                    else if (rw_r)               state_nx = RD_BYTE;
                    else                         state_nx = WAIT_WR;
                end
            end
            WAIT_WR: begin
                scl_low = 1'b1;
                if (wr_valid) state_nx = WR_BYTE;
            end
            WR_BYTE: begin
                scl_low = !quarter[1];
                sda_low = !tx[7];
                if (bit_end && bitcnt == 3'd7) state_nx = WR_ACK;
            end
            WR_ACK: begin
                scl_low = !quarter[1];
                if (bit_end) state_nx = (samp || remaining == LEN_W'(1)) ? STOP : WAIT_WR;
            end
            RD_BYTE: begin
                scl_low = !quarter[1];
                if (bit_end && bitcnt == 3'd7) state_nx = RD_ACK;
            end
            RD_ACK: begin
                scl_low = !quarter[1];
                sda_low = (remaining != LEN_W'(1));
                if (bit_end) state_nx = (remaining == LEN_W'(1)) ? STOP : RD_BYTE;
            end
            STOP: begin
                scl_low = (quarter == 2'd0);
                sda_low = (quarter != 2'd3);
                if (bit_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bit timing: quarters wrap naturally across state changes; only IDLE/WAIT_WR park at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qcnt    <= '0;
            quarter <= '0;
            bitcnt  <= '0;
        end else if (!counting) begin
            qcnt    <= '0;
            quarter <= '0;
            bitcnt  <= '0;
        end else if (!stall) begin
            if (qcnt == Q_LAST) begin
                qcnt    <= '0;
                quarter <= quarter + 2'd1;
                if (quarter == 2'd3 && shifting) bitcnt <= bitcnt + 3'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx        <= '0;
            rx        <= '0;
            rw_r      <= 1'b0;
            remaining <= '0;
            samp      <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (state == IDLE && enable) begin
                tx        <= {addr, rw};
                rw_r      <= rw;
                remaining <= len;
                nack      <= 1'b0;
            end
            if (state == WAIT_WR && wr_valid) tx <= wr_data;
            if (bit_end && (state == ADDR || state == WR_BYTE)) tx <= {tx[6:0], 1'b0};
            if (sample_pt) samp <= i2c_sda;
            if (sample_pt && state == RD_BYTE) begin
                rx <= {rx[6:0], i2c_sda};
                if (bitcnt == 3'd7) begin
                    rd_data  <= {rx[6:0], i2c_sda};
                    rd_valid <= 1'b1;
                end
            end
            if (bit_end && (state == ADDR_ACK || state == WR_ACK) && samp) nack <= 1'b1;
            if (bit_end && ((state == WR_ACK && !samp) || state == RD_ACK))
                remaining <= remaining - LEN_W'(1);
            if (bit_end && state == STOP) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_controller_burst.sv
// Directed bench for i2c_controller_burst with a behavioural I2C slave at 7'h2A on pulled-up lines.
module tb_i2c_controller_burst;

    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned LEN_W    = 8;
    localparam logic [6:0]  SLV_ADDR = 7'h2A;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [6:0]       addr = '0;
    logic             rw = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             enable = 1'b0;
    logic [7:0]       wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             ready;
    logic             done;
    logic             nack;
    wire              sda;
    wire              scl;

    pullup (sda);
    pullup (scl);

    i2c_controller_burst #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rw(rw), .len(len), .enable(enable),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .ready(ready), .done(done),
        .nack(nack), .i2c_sda(sda), .i2c_scl(scl)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural slave ----------------
    typedef enum logic [2:0] {S_OFF, S_ADDR, S_AACK, S_WRITE, S_READ} sphase_t;
    sphase_t    sphase = S_OFF;
    int         bitn = -2;
    int         rd_idx = 0;
    int         hold_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] srx = '0;
    logic [7:0] stx = '0;
    logic       srw = 1'b0;
    logic       p_sda = 1'b1, p_scl = 1'b1;
    logic       sda_v, scl_v;
    logic       s_sda_low = 1'b0, s_scl_low = 1'b0;
    bit         stretch_arm = 1'b0;
    logic [7:0] rd_bytes [3] = '{8'h11, 8'h22, 8'h33};
    logic [8:0] frames [$];
    logic [7:0] slave_wr [$];

    assign sda = s_sda_low ? 1'b0 : 1'bz;
    assign scl = s_scl_low ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        sda_v = (sda !== 1'b0);
        scl_v = (scl !== 1'b0);
        if (hold_cnt > 0) begin
            hold_cnt = hold_cnt - 1;
            if (hold_cnt == 0) s_scl_low = 1'b0;
        end
        if (scl_v && p_scl && p_sda && !sda_v) begin
            start_cnt = start_cnt + 1;
            sphase = S_ADDR; bitn = -1; s_sda_low = 1'b0; srx = '0;
        end else if (scl_v && p_scl && !p_sda && sda_v) begin
            stop_cnt = stop_cnt + 1;
            sphase = S_OFF; bitn = -2; s_sda_low = 1'b0;
        end else if (scl_v && !p_scl) begin
            if (bitn >= 0 && bitn < 8) srx = {srx[6:0], sda_v};
            else if (bitn == 8) begin
                frames.push_back({srx, sda_v});
                if (sphase == S_READ) begin
                    if (sda_v) sphase = S_OFF;
                    else rd_idx = rd_idx + 1;
                end
            end
        end else if (!scl_v && p_scl && bitn >= -1) begin
            bitn = (bitn == 8) ? 0 : bitn + 1;
            s_sda_low = 1'b0;
            case (sphase)
                S_ADDR: if (bitn == 8) begin
                    if (srx[7:1] == SLV_ADDR) begin
                        s_sda_low = 1'b1; srw = srx[0]; sphase = S_AACK;
                    end else sphase = S_OFF;
                end
                S_AACK: begin
                    sphase = srw ? S_READ : S_WRITE;
                    rd_idx = 0;
                    if (srw) begin
                        stx = rd_bytes[0];
                        s_sda_low = !stx[7];
                        if (stretch_arm) begin s_scl_low = 1'b1; hold_cnt = 24; end
                    end
                end
                S_WRITE: if (bitn == 8) begin slave_wr.push_back(srx); s_sda_low = 1'b1; end
                S_READ: if (bitn < 8 && rd_idx < 3) begin
                    stx = rd_bytes[rd_idx];
                    s_sda_low = !stx[7 - bitn];
                end
                default: ;
            endcase
        end
        p_sda = sda_v;
        p_scl = scl_v;
    end

    // ---------------- transfer driver ----------------
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  wr_src [$];
    logic [7:0]  rd_seen [$];
    int          xfer_cycles;
    bit          xfer_done, saw_wr_ready, stall_ok, en_nack, en_ready, ready_at_done;

    task automatic run_xfer(input logic [6:0] a, input logic r, input logic [LEN_W-1:0] n,
                            input int stall_cycles);
        int idx = 0;
        int sent = 0;
        int stall_left = stall_cycles;
        rd_seen.delete(); frames.delete(); slave_wr.delete();
        start_cnt = 0; stop_cnt = 0;
        xfer_done = 1'b0; saw_wr_ready = 1'b0; stall_ok = 1'b1; xfer_cycles = 0; ready_at_done = 1'b0;
        @(negedge clk);
        addr = a; rw = r; len = n; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        en_nack = nack; en_ready = ready;
        addr = ~a; rw = ~r; len = n + 1'b1;
        for (int c = 1; c < 3000 && !xfer_done; c++) begin
            if (rd_valid) rd_seen.push_back(rd_data);
            if (wr_ready) saw_wr_ready = 1'b1;
            if (wr_valid) begin
                wr_valid = 1'b0;
                sent++;
            end else if (wr_ready && idx < wr_src.size()) begin
                if (sent == 1 && stall_left > 0) begin
                    if (scl !== 1'b0) stall_ok = 1'b0;
                    stall_left--;
                end else begin
                    wr_data = wr_src[idx]; idx++; wr_valid = 1'b1;
                end
            end
            if (done) begin
                xfer_done = 1'b1; xfer_cycles = c; ready_at_done = ready;
            end else @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        n_vec++; if ({rd_valid, done, nack} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {rd_valid, done, nack}); end
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        n_vec++; if ({sda, scl} !== 2'b11) begin n_err++; $display("FAIL reset_lines got %b want 11", {sda, scl}); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_single();
        logic [8:0] exp [2] = '{9'h0A8, 9'h154};
        wr_src = '{8'hAA};
        run_xfer(7'h2A, 1'b0, 8'd1, 0);
        n_vec++; if (xfer_done !== 1'b1) begin n_err++; $display("FAIL wr1_done got %b want 1", xfer_done); end
        n_vec++; if ({en_nack, en_ready} !== 2'b00) begin n_err++; $display("FAIL wr1_after_enable got %b want 00", {en_nack, en_ready}); end
        n_vec++; if (nack !== 1'b0) begin n_err++; $display("FAIL wr1_nack got %b want 0", nack); end
        n_vec++; if (frames.size() != 2) begin n_err++; $display("FAIL wr1_frames got %0d want 2", frames.size()); end
        else for (int i = 0; i < 2; i++) begin
            n_vec++; if (frames[i] !== exp[i]) begin n_err++; $display("FAIL wr1_frame%0d got %h want %h", i, frames[i], exp[i]); end
        end
        n_vec++; if (slave_wr.size() != 1 || slave_wr[0] !== 8'hAA) begin n_err++; $display("FAIL wr1_slave got %0d bytes want 1 byte AA", slave_wr.size()); end
        n_vec++; if ({start_cnt, stop_cnt} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL wr1_start_stop got %0d/%0d want 1/1", start_cnt, stop_cnt); end
        n_vec++; if (ready_at_done !== 1'b1) begin n_err++; $display("FAIL wr1_ready_at_done got %b want 1", ready_at_done); end
    endtask

    task automatic test_read_burst();
        logic [8:0] exp [4] = '{9'h0AA, 9'h022, 9'h044, 9'h067};
        logic [7:0] exp_rd [3] = '{8'h11, 8'h22, 8'h33};
        wr_src.delete();
        run_xfer(7'h2A, 1'b1, 8'd3, 0);
        n_vec++; if (xfer_done !== 1'b1) begin n_err++; $display("FAIL rd3_done got %b want 1", xfer_done); end
        n_vec++; if (rd_seen.size() != 3) begin n_err++; $display("FAIL rd3_count got %0d want 3", rd_seen.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++; if (rd_seen[i] !== exp_rd[i]) begin n_err++; $display("FAIL rd3_data%0d got %h want %h", i, rd_seen[i], exp_rd[i]); end
        end
        n_vec++; if (frames.size() != 4) begin n_err++; $display("FAIL rd3_frames got %0d want 4", frames.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_vec++; if (frames[i] !== exp[i]) begin n_err++; $display("FAIL rd3_frame%0d got %h want %h", i, frames[i], exp[i]); end
        end
        n_vec++; if ({nack, saw_wr_ready} !== 2'b00) begin n_err++; $display("FAIL rd3_nack_wrready got %b want 00", {nack, saw_wr_ready}); end
        n_vec++; if (stop_cnt != 1) begin n_err++; $display("FAIL rd3_stop got %0d want 1", stop_cnt); end
    endtask

    task automatic test_addr_nack();
        wr_src = '{8'hE1, 8'hE2};
        run_xfer(7'h15, 1'b0, 8'd2, 0);
        n_vec++; if (xfer_done !== 1'b1) begin n_err++; $display("FAIL anack_done got %b want 1", xfer_done); end
        n_vec++; if (nack !== 1'b1) begin n_err++; $display("FAIL anack_nack got %b want 1", nack); end
        n_vec++; if (saw_wr_ready !== 1'b0) begin n_err++; $display("FAIL anack_wr_ready got %b want 0", saw_wr_ready); end
        n_vec++; if (frames.size() != 1 || frames[0] !== 9'h055) begin n_err++; $display("FAIL anack_frames got %0d frames want 1 frame 055", frames.size()); end
        n_vec++; if (stop_cnt != 1 || slave_wr.size() != 0) begin n_err++; $display("FAIL anack_bus got stop=%0d wr=%0d want 1/0", stop_cnt, slave_wr.size()); end
        wr_src.delete();
        run_xfer(7'h2A, 1'b0, 8'd0, 0);
        n_vec++; if (en_nack !== 1'b0) begin n_err++; $display("FAIL probe_nack_clear got %b want 0", en_nack); end
        n_vec++; if ({xfer_done, nack, saw_wr_ready} !== 3'b100) begin n_err++; $display("FAIL probe_status got %b want 100", {xfer_done, nack, saw_wr_ready}); end
        n_vec++; if (frames.size() != 1 || frames[0] !== 9'h0A8) begin n_err++; $display("FAIL probe_frames got %0d frames want 1 frame 0a8", frames.size()); end
    endtask

    task automatic test_wr_stall();
        logic [8:0] exp [3] = '{9'h0A8, 9'h078, 9'h0B8};
        wr_src = '{8'h3C, 8'h5C};
        run_xfer(7'h2A, 1'b0, 8'd2, 50);
        n_vec++; if (xfer_done !== 1'b1) begin n_err++; $display("FAIL stall_done got %b want 1", xfer_done); end
        n_vec++; if (stall_ok !== 1'b1) begin n_err++; $display("FAIL stall_scl_low got %b want 1", stall_ok); end
        n_vec++; if (frames.size() != 3) begin n_err++; $display("FAIL stall_frames got %0d want 3", frames.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++; if (frames[i] !== exp[i]) begin n_err++; $display("FAIL stall_frame%0d got %h want %h", i, frames[i], exp[i]); end
        end
        n_vec++; if (slave_wr.size() != 2 || slave_wr[1] !== 8'h5C) begin n_err++; $display("FAIL stall_slave got %0d bytes want 2 ending 5C", slave_wr.size()); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        addr = 7'h2A; rw = 1'b0; len = 8'd1; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if ({sda, scl} !== 2'b11) begin n_err++; $display("FAIL rstmid_lines got %b want 11", {sda, scl}); end
        n_vec++; if ({ready, nack, wr_ready} !== 3'b100) begin n_err++; $display("FAIL rstmid_status got %b want 100", {ready, nack, wr_ready}); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wr_src = '{8'h77};
        run_xfer(7'h2A, 1'b0, 8'd1, 0);
        n_vec++; if ({xfer_done, nack} !== 2'b10) begin n_err++; $display("FAIL rstmid_xfer got %b want 10", {xfer_done, nack}); end
        n_vec++; if (frames.size() != 2 || frames[1] !== 9'h0EE) begin n_err++; $display("FAIL rstmid_frames got %0d frames want 2 ending 0ee", frames.size()); end
    endtask

`ifdef CLOCK_STRETCH_EN
    task automatic test_clock_stretch();
        int base;
        wr_src.delete();
        stretch_arm = 1'b0;
        run_xfer(7'h2A, 1'b1, 8'd1, 0);
        base = xfer_cycles;
        stretch_arm = 1'b1;
        run_xfer(7'h2A, 1'b1, 8'd1, 0);
        stretch_arm = 1'b0;
        n_vec++; if (xfer_done !== 1'b1) begin n_err++; $display("FAIL stretch_done got %b want 1", xfer_done); end
        n_vec++; if (xfer_cycles - base != 20) begin n_err++; $display("FAIL stretch_extra got %0d want 20", xfer_cycles - base); end
        n_vec++; if (rd_seen.size() != 1 || rd_seen[0] !== 8'h11) begin n_err++; $display("FAIL stretch_data got %0d bytes want 1 byte 11", rd_seen.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_single();
        test_read_burst();
        test_addr_nack();
        test_wr_stall();
        test_reset_mid();
`ifdef CLOCK_STRETCH_EN
        test_clock_stretch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
